priority_encoder_iter: RTL and testbench



---
 rtl/priority_encoder_pkg.sv | 21 ++
 rtl/priority_encoder_sel.sv | 46 ++++
 rtl/priority_encoder_iter.sv | 158 +++++++++++++++
 tb/tb_priority_encoder_iter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared types and the index-width derivation for the priority encoder family.
package priority_encoder_pkg;

    typedef enum logic {
        DIR_LSB = 1'b0,
        DIR_MSB = 1'b1
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index width for a WIDTH-bit word, never narrower than one bit.
    function automatic int calc_idx_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/priority_encoder_sel.sv
// Combinational pick of the lowest (dir=LSB) or highest (dir=MSB) set bit of a mask.
// MSB-first is done by reversing the mask, isolating the lowest bit, and reversing back.
module priority_encoder_sel
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i_mask,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_one
);

    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_onehot;
    logic [IDX_W-1:0] w_low_idx;
    logic             w_any;
    logic             w_msb;

    assign w_msb = (i_dir == DIR_MSB);
    assign w_any = |i_mask;

    // Isolate the selected bit and encode its position.
    always_comb begin
        w_rev     = {WIDTH{1'b0}};
        w_onehot  = {WIDTH{1'b0}};
        w_low_idx = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = w_msb ? i_mask[WIDTH-1-i] : i_mask[i];
        end
        w_low = w_rev & (~w_rev + {{(WIDTH-1){1'b0}}, 1'b1});
        for (int i = 0; i < WIDTH; i++) begin
            w_low_idx = w_low_idx | (w_low[i] ? IDX_W'(i) : {IDX_W{1'b0}});
            w_onehot[i] = w_msb ? w_low[WIDTH-1-i] : w_low[i];
        end
    end

    assign o_onehot = w_onehot;
    assign o_idx    = !w_any ? {IDX_W{1'b0}}
                    : (w_msb ? (IDX_W'(WIDTH-1) - w_low_idx) : w_low_idx);
    assign o_one    = w_any && ((i_mask & (i_mask - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});

endmodule

// File: rtl/priority_encoder_iter.sv
// Iterative priority encoder: one output beat per set bit of each accepted word.
// Optional macro PRIORITY_ENCODER_ITER_ZERO_BEAT_EN makes an all-zero word emit one empty beat.
module priority_encoder_iter
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] data_onehot_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic             data_last_o,
    output logic             data_empty_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    state_t           r_state;
    dir_t             r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_onehot;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic             r_val;
    logic             r_ready;
`ifdef PRIORITY_ENCODER_ITER_ZERO_BEAT_EN
    logic             r_empty;
`endif

    logic [WIDTH-1:0] w_sel_mask;
    logic             w_sel_dir;
    logic [WIDTH-1:0] w_sel_onehot;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_one;
    logic             w_sel_any;
    logic             w_accept;
    logic             w_beat_done;

    assign w_accept    = (r_state == IDLE) && r_ready && data_val_i;
    assign w_beat_done = (r_state == BUSY) && r_val && data_ready_i;

    // In IDLE the selector looks at the incoming word; in BUSY at the mask minus the current bit.
    always_comb begin
        w_sel_mask = {WIDTH{1'b0}};
        w_sel_dir  = 1'b0;
        if (r_state == IDLE) begin
            w_sel_mask = data_i;
            w_sel_dir  = dir_i;
        end else begin
            w_sel_mask = r_mask & ~r_onehot;
            w_sel_dir  = r_dir;
        end
    end

    assign w_sel_any = |w_sel_mask;

    priority_encoder_sel #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .i_mask   (w_sel_mask),
        .i_dir    (w_sel_dir),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx),
        .o_one    (w_sel_one)
    );

    // Control FSM with mask and output registers.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state  <= IDLE;
            r_dir    <= DIR_LSB;
            r_mask   <= {WIDTH{1'b0}};
            r_onehot <= {WIDTH{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_last   <= 1'b0;
            r_val    <= 1'b0;
            r_ready  <= 1'b0;
`ifdef PRIORITY_ENCODER_ITER_ZERO_BEAT_EN
            r_empty  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_mask <= data_i;
                        r_dir  <= dir_t'(dir_i);
                        if (w_sel_any) begin
                            r_state  <= BUSY;
                            r_ready  <= 1'b0;
                            r_val    <= 1'b1;
                            r_onehot <= w_sel_onehot;
                            r_idx    <= w_sel_idx;
                            r_last   <= w_sel_one;
                        end else begin
`ifdef PRIORITY_ENCODER_ITER_ZERO_BEAT_EN
                            r_state  <= BUSY;
                            r_ready  <= 1'b0;
                            r_val    <= 1'b1;
                            r_onehot <= {WIDTH{1'b0}};
                            r_idx    <= {IDX_W{1'b0}};
                            r_last   <= 1'b1;
                            r_empty  <= 1'b1;
`else
                            r_state  <= IDLE;
`endif
                        end
                    end
                end
                BUSY: begin
                    r_ready <= 1'b0;
                    if (w_beat_done) begin
                        if (r_last) begin
                            r_state  <= IDLE;
                            r_ready  <= 1'b1;
                            r_val    <= 1'b0;
                            r_last   <= 1'b0;
                            r_onehot <= {WIDTH{1'b0}};
                            r_idx    <= {IDX_W{1'b0}};
                            r_mask   <= {WIDTH{1'b0}};
`ifdef PRIORITY_ENCODER_ITER_ZERO_BEAT_EN
                            r_empty  <= 1'b0;
`endif
                        end else begin
                            r_mask   <= w_sel_mask;
                            r_onehot <= w_sel_onehot;
                            r_idx    <= w_sel_idx;
                            r_last   <= w_sel_one;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_val   <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready_o  = r_ready;
    assign data_val_o    = r_val;
    assign data_onehot_o = r_onehot;
    assign data_idx_o    = r_idx;
    assign data_last_o   = r_last;
`ifdef PRIORITY_ENCODER_ITER_ZERO_BEAT_EN
    assign data_empty_o  = r_empty;
`else
    assign data_empty_o  = 1'b0;
`endif

endmodule

// File: tb/tb_priority_encoder_iter.sv
// Directed self-checking bench for priority_encoder_iter (WIDTH=32).
module tb_priority_encoder_iter;

    logic        clk;
    logic        srst_i;
    logic [31:0] data_i;
    logic        dir_i;
    logic        data_val_i;
    logic        data_ready_o;
    logic [31:0] data_onehot_o;
    logic [4:0]  data_idx_o;
    logic        data_last_o;
    logic        data_empty_o;
    logic        data_val_o;
    logic        data_ready_i;

    int tests_run;
    int tests_failed;

    priority_encoder_iter #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .srst_i        (srst_i),
        .data_i        (data_i),
        .dir_i         (dir_i),
        .data_val_i    (data_val_i),
        .data_ready_o  (data_ready_o),
        .data_onehot_o (data_onehot_o),
        .data_idx_o    (data_idx_o),
        .data_last_o   (data_last_o),
        .data_empty_o  (data_empty_o),
        .data_val_o    (data_val_o),
        .data_ready_i  (data_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        srst_i = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({data_val_o, data_ready_o, data_last_o, data_empty_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags got val/rdy/last/empty=%b want 0000",
                     {data_val_o, data_ready_o, data_last_o, data_empty_o});
        end
        tests_run++;
        if (data_onehot_o !== 32'h0 || data_idx_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_data got onehot=%h idx=%0d want 0/0", data_onehot_o, data_idx_o);
        end
        srst_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (data_ready_o !== 1'b1 || data_val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release got rdy=%b val=%b want 1/0", data_ready_o, data_val_o);
        end
    endtask

    task automatic test_lsb();
        int exp_idx [3] = '{0, 4, 15};
        tests_run++;
        if (data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsb_ready got %b want 1", data_ready_o);
        end
        data_i = 32'h0000_8011; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tests_run++;
            if (data_val_o !== 1'b1 || data_idx_o !== 5'(exp_idx[b]) ||
                data_onehot_o !== (32'd1 << exp_idx[b]) || data_last_o !== (b == 2)) begin
                tests_failed++;
                $display("FAIL lsb_beat%0d got val=%b idx=%0d oh=%h last=%b want idx=%0d last=%b",
                         b, data_val_o, data_idx_o, data_onehot_o, data_last_o, exp_idx[b], b == 2);
            end
            @(negedge clk);
        end
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsb_end got val=%b rdy=%b want 0/1", data_val_o, data_ready_o);
        end
    endtask

    task automatic test_msb();
        int exp_idx [3] = '{15, 4, 0};
        data_i = 32'h0000_8011; dir_i = 1'b1; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tests_run++;
            if (data_val_o !== 1'b1 || data_idx_o !== 5'(exp_idx[b]) ||
                data_onehot_o !== (32'd1 << exp_idx[b]) || data_last_o !== (b == 2) ||
                data_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL msb_beat%0d got val=%b idx=%0d oh=%h last=%b rdy=%b want idx=%0d",
                         b, data_val_o, data_idx_o, data_onehot_o, data_last_o, data_ready_o, exp_idx[b]);
            end
            @(negedge clk);
        end
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL msb_ready_return got val=%b rdy=%b want 0/1", data_val_o, data_ready_o);
        end
    endtask

    task automatic test_backpressure();
        data_i = 32'h0000_8011; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        tests_run++;
        if (data_idx_o !== 5'd0 || data_val_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_first got idx=%0d val=%b want 0/1", data_idx_o, data_val_o);
        end
        @(negedge clk);
        data_ready_i = 1'b0;
        data_i = 32'hFFFF_0000; data_val_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (data_val_o !== 1'b1 || data_idx_o !== 5'd4 || data_onehot_o !== 32'h10 ||
                data_last_o !== 1'b0 || data_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d got val=%b idx=%0d oh=%h last=%b rdy=%b want 1/4/10/0/0",
                         c, data_val_o, data_idx_o, data_onehot_o, data_last_o, data_ready_o);
            end
        end
        data_val_i = 1'b0;
        data_ready_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (data_val_o !== 1'b1 || data_idx_o !== 5'd15 || data_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got val=%b idx=%0d last=%b want 1/15/1", data_val_o, data_idx_o, data_last_o);
        end
        @(negedge clk);
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_end got val=%b rdy=%b want 0/1", data_val_o, data_ready_o);
        end
    endtask

    task automatic test_full_word();
        data_i = 32'hFFFF_FFFF; dir_i = 1'b1; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        for (int b = 0; b < 32; b++) begin
            tests_run++;
            if (data_val_o !== 1'b1 || data_idx_o !== 5'(31 - b) ||
                data_onehot_o !== (32'h8000_0000 >> b) || data_last_o !== (b == 31)) begin
                tests_failed++;
                $display("FAIL full_beat%0d got val=%b idx=%0d oh=%h last=%b want idx=%0d",
                         b, data_val_o, data_idx_o, data_onehot_o, data_last_o, 31 - b);
            end
            @(negedge clk);
        end
        data_i = 32'h0000_0001; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        tests_run++;
        if (data_val_o !== 1'b1 || data_idx_o !== 5'd0 || data_onehot_o !== 32'h1 || data_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_beat got val=%b idx=%0d oh=%h last=%b want 1/0/1/1",
                     data_val_o, data_idx_o, data_onehot_o, data_last_o);
        end
        @(negedge clk);
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_end got val=%b rdy=%b want 0/1", data_val_o, data_ready_o);
        end
    endtask

    task automatic test_zero_word();
        data_i = 32'h0; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
`ifdef PRIORITY_ENCODER_ITER_ZERO_BEAT_EN
        tests_run++;
        if (data_val_o !== 1'b1 || data_empty_o !== 1'b1 || data_last_o !== 1'b1 ||
            data_onehot_o !== 32'h0 || data_idx_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL zero_beat got val=%b empty=%b last=%b oh=%h idx=%0d want 1/1/1/0/0",
                     data_val_o, data_empty_o, data_last_o, data_onehot_o, data_idx_o);
        end
        @(negedge clk);
`endif
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b1 || data_empty_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_after got val=%b rdy=%b empty=%b want 0/1/0", data_val_o, data_ready_o, data_empty_o);
        end
    endtask

    task automatic test_reset_mid_word();
        data_i = 32'h0000_00FF; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (data_val_o !== 1'b1 || data_idx_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL abort_beat2 got val=%b idx=%0d want 1/1", data_val_o, data_idx_o);
        end
        srst_i = 1'b1;
        @(negedge clk);
        srst_i = 1'b0;
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b0 || data_last_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_reset got val=%b rdy=%b last=%b want 0/0/0", data_val_o, data_ready_o, data_last_o);
        end
        @(negedge clk);
        tests_run++;
        if (data_ready_o !== 1'b1 || data_val_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_idle got rdy=%b val=%b want 1/0", data_ready_o, data_val_o);
        end
        data_i = 32'h0000_0004; dir_i = 1'b0; data_val_i = 1'b1;
        @(negedge clk);
        data_val_i = 1'b0;
        tests_run++;
        if (data_val_o !== 1'b1 || data_idx_o !== 5'd2 || data_onehot_o !== 32'h4 || data_last_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_abort got val=%b idx=%0d oh=%h last=%b want 1/2/4/1",
                     data_val_o, data_idx_o, data_onehot_o, data_last_o);
        end
        @(negedge clk);
        tests_run++;
        if (data_val_o !== 1'b0 || data_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_abort_end got val=%b rdy=%b want 0/1", data_val_o, data_ready_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        srst_i       = 1'b1;
        data_i       = 32'h0;
        dir_i        = 1'b0;
        data_val_i   = 1'b0;
        data_ready_i = 1'b1;
        test_reset();
        test_lsb();
        test_msb();
        test_backpressure();
        test_full_word();
        test_zero_word();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
